// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of a
// single-port data memory (synchronous write, combinational read).
// Port 0 is the CPU load/store path; port 1 is the host/sort-engine/loader.
//
// Handshake: a requester raises req (with we/lock/addr/wdata valid) and holds
// it until it sees gnt; gnt is combinational and the access is taken at the
// rising edge where req & gnt are both high. Read data returns one cycle later
// as a one-cycle rvalid pulse; an out-of-range access returns a one-cycle err
// pulse instead and leaves rdata untouched.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    logic              last;       // port that won the most recent access
    logic              g0;
    logic              g1;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    // Grant decision: round-robin in ARB, locked port only in LOCKn, nothing in reset.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            case (state)
                ARB: begin
                    if (req0 && req1) begin
                        g0 = last;
                        g1 = !last;
                    end else begin
                        g0 = req0;
                        g1 = req1;
                    end
                end
                LOCK0:   g0 = req0;
                LOCK1:   g1 = req1;
                default: begin
                    g0 = 1'b0;
                    g1 = 1'b0;
                end
            endcase
        end
    end

    // Route the winner's request onto the memory port; idle bus is all zeros.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (g0) begin
            sel_we    = we0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (g1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    assign in_range = (sel_addr[31:ADDR_W] == '0);
    assign mem_we   = (g0 | g1) & sel_we & in_range;
    assign mem_addr = sel_addr[ADDR_W-1:0];
    assign mem_din  = sel_wdata;
    assign gnt0     = g0;
    assign gnt1     = g1;

    // Arbitration state, round-robin pointer and registered read/err responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            last    <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;

            if (g0) begin
                last <= 1'b0;
                if (!in_range) begin
                    err0 <= 1'b1;
                end else if (!we0) begin
                    rvalid0 <= 1'b1;
                    rdata0  <= mem_dout;
                end
            end

            if (g1) begin
                last <= 1'b1;
                if (!in_range) begin
                    err1 <= 1'b1;
                end else if (!we1) begin
                    rvalid1 <= 1'b1;
                    rdata1  <= mem_dout;
                end
            end

            // A lock is only taken on an accepted access and is released
            // purely by the owner dropping lock, whether or not it requests.
            case (state)
                ARB: begin
                    if (g0 && lock0) begin
                        state <= LOCK0;
                    end else if (g1 && lock1) begin
                        state <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (!lock0) begin
                        state <= ARB;
                    end
                end
                LOCK1: begin
                    if (!lock1) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
